pg_carry_resolver: RTL

PG_CARRY_RESOLVER -- requirements
Module: pg_carry_resolver

---
 rtl/pg_carry_if.sv | 24 ++
 rtl/pg_carry_resolver.sv | 79 +++++++
 2 files changed

// File: rtl/pg_carry_if.sv
// pg_carry_if: operand/result handshake bundle for pg_carry_resolver.
// The ovf signal exists only when PG_OVERFLOW_EN is defined.
interface pg_carry_if;
    logic [31:0] pg_in;
    logic        cin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready;
`ifdef PG_OVERFLOW_EN
    logic        ovf;
    modport master (output pg_in, cin, in_valid, out_ready,
                    input  in_ready, sum, cout, out_valid, ovf);
    modport slave  (input  pg_in, cin, in_valid, out_ready,
                    output in_ready, sum, cout, out_valid, ovf);
`else
    modport master (output pg_in, cin, in_valid, out_ready,
                    input  in_ready, sum, cout, out_valid);
    modport slave  (input  pg_in, cin, in_valid, out_ready,
                    output in_ready, sum, cout, out_valid);
`endif
endinterface

// File: rtl/pg_carry_resolver.sv
// pg_carry_resolver: multi-cycle Kogge-Stone carry resolver, one prefix level per cycle.
// Optional signed-overflow output enabled by PG_OVERFLOW_EN.
module pg_carry_resolver (
    input logic       clk,
    input logic       rst_n,
    pg_carry_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMBINE, DONE} state_t;
    state_t      state;
    logic [1:0]  lvl;
    logic [15:0] p, g, p_orig, p_nxt, g_nxt, p_in, g_in;
    logic        cin_r, out_valid_r;
    logic [4:0]  span;
`ifdef PG_OVERFLOW_EN
    logic        ovf_r;
`endif
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            p_in[i] = bus.pg_in[2*i+1];
            g_in[i] = bus.pg_in[2*i];
        end
        span = 5'd1 << lvl;
        // shifted-in zeros leave bits below span untouched
        g_nxt = g | (p & (g << span));
        p_nxt = p & ((p << span) | ~(16'hFFFF << span));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lvl         <= 2'd0;
            p           <= 16'h0;
            g           <= 16'h0;
            p_orig      <= 16'h0;
            cin_r       <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef PG_OVERFLOW_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    p_orig <= p_in;
                    p      <= p_in;
                    g      <= {g_in[15:1], g_in[0] | (p_in[0] & bus.cin)};
                    cin_r  <= bus.cin;
                    lvl    <= 2'd0;
                    state  <= COMBINE;
                end
                COMBINE: begin
                    p   <= p_nxt;
                    g   <= g_nxt;
                    lvl <= lvl + 2'd1;
                    if (lvl == 2'd3) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
`ifdef PG_OVERFLOW_EN
                        ovf_r       <= g_nxt[14] ^ g_nxt[15];
`endif
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
`ifdef PG_OVERFLOW_EN
                    ovf_r       <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = p_orig ^ {g[14:0], cin_r};
    assign bus.cout      = g[15];
`ifdef PG_OVERFLOW_EN
    assign bus.ovf       = ovf_r;
`endif
endmodule
